// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: round-robin N-master to 1-slave req/gnt/rvalid arbiter with request lock and in-order response routing
module core_bus_arbiter #(
  parameter int N = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_OUT = 4,
  localparam int BW = DW / 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1,
  localparam int CW = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]    m_req,
  output logic [N-1:0]    m_gnt,
  output logic [N-1:0]    m_rvalid,
  input  logic [N-1:0]    m_we,
  input  logic [N*BW-1:0] m_be,
  input  logic [N*AW-1:0] m_addr,
  input  logic [N*DW-1:0] m_wdata,
  output logic [N*DW-1:0] m_rdata,
  output logic [N-1:0]    m_err,
  output logic          s_req,
  input  logic          s_gnt,
  input  logic          s_rvalid,
  output logic          s_we,
  output logic [BW-1:0] s_be,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_err,
  output logic [CW-1:0] outstanding,
  output logic          resp_err
);
  logic [IW-1:0] ptr, lock_idx, sel, idx, head;
  logic [IW-1:0] fifo [MAX_OUT];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic lock, found, hs, pop, resp_err_q;
  always_comb begin
    sel = lock ? lock_idx : ptr;
    found = lock;
    idx = ptr;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && m_req[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  assign s_req = (|m_req) && (count < CW'(MAX_OUT)) && !rst;
  assign hs = s_req & s_gnt;
  assign pop = s_rvalid & (count != '0) & !rst;
  assign head = fifo[rd_ptr];
  assign s_we = m_we[sel];
  assign s_be = m_be[int'(sel)*BW +: BW];
  assign s_addr = m_addr[int'(sel)*AW +: AW];
  assign s_wdata = m_wdata[int'(sel)*DW +: DW];
  assign m_gnt = hs ? N'(1) << sel : '0;
  assign m_rvalid = pop ? N'(1) << head : '0;
  assign m_err = (pop & s_err) ? N'(1) << head : '0;
  assign m_rdata = {N{s_rdata}};
  assign outstanding = rst ? '0 : count;
  assign resp_err = resp_err_q & !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      lock <= 1'b0;
      lock_idx <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      resp_err_q <= 1'b0;
    end else begin
      lock <= s_req & ~s_gnt;
      lock_idx <= sel;
      count <= count + CW'(hs) - CW'(pop);
      if (hs) ptr <= (int'(sel) == N - 1) ? '0 : sel + 1'b1;
      if (hs) wr_ptr <= (int'(wr_ptr) == MAX_OUT - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (int'(rd_ptr) == MAX_OUT - 1) ? '0 : rd_ptr + 1'b1;
      if (s_rvalid && count == '0) resp_err_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (hs) fifo[wr_ptr] <= sel;
  end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed and randomized checks of core_bus_arbiter against a queue-based reference model
module tb_core_bus_arbiter;
  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_OUT = 4;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(MAX_OUT + 1);
  logic clk, rst;
  logic [N-1:0] m_req, m_gnt, m_rvalid, m_we, m_err;
  logic [N*BW-1:0] m_be;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata, m_rdata;
  logic s_req, s_gnt, s_rvalid, s_we, s_err, resp_err;
  logic [BW-1:0] s_be;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [CW-1:0] outstanding;
  int tests_run = 0;
  int tests_failed = 0;
  int mq[$];
  int mptr, mlock_idx, exp_sel, exp_out;
  bit mlock, mresp_err, exp_sreq, exp_pop, exp_re;
  logic [N-1:0] exp_gnt, exp_rv, exp_err;
  core_bus_arbiter #(.N(N), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_we(m_we), .m_be(m_be),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_we(s_we), .s_be(s_be),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_err(s_err),
    .outstanding(outstanding), .resp_err(resp_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void model_eval();
    bit found;
    exp_sel = mlock ? mlock_idx : mptr;
    found = mlock;
    for (int k = 0; k < N; k++) begin
      if (!found && m_req[(mptr + k) % N]) begin
        exp_sel = (mptr + k) % N;
        found = 1'b1;
      end
    end
    exp_sreq = !rst && (m_req != '0) && (mq.size() < MAX_OUT);
    exp_gnt = (exp_sreq && s_gnt) ? N'(1) << exp_sel : '0;
    exp_pop = !rst && s_rvalid && (mq.size() > 0);
    exp_rv = exp_pop ? N'(1) << mq[0] : '0;
    exp_err = (exp_pop && s_err) ? N'(1) << mq[0] : '0;
    exp_out = rst ? 0 : mq.size();
    exp_re = rst ? 1'b0 : mresp_err;
  endfunction
  function automatic void model_commit();
    if (rst) begin
      mq.delete();
      mptr = 0;
      mlock = 1'b0;
      mresp_err = 1'b0;
    end else begin
      if (s_rvalid) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else mresp_err = 1'b1;
      end
      if (exp_sreq && s_gnt) begin
        mq.push_back(exp_sel);
        mptr = (exp_sel + 1) % N;
        mlock = 1'b0;
      end else if (exp_sreq) begin
        mlock = 1'b1;
        mlock_idx = exp_sel;
      end
    end
  endfunction
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask
  task automatic set_m(input int i, input logic [AW-1:0] a);
    m_req[i] = 1'b1;
    m_addr[i*AW +: AW] = a;
    m_we[i] = 1'b0;
    m_be[i*BW +: BW] = '1;
    m_wdata[i*DW +: DW] = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    m_req = '0;
    s_gnt = 1'b0;
    s_rvalid = 1'b0;
    s_err = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    m_req = '1;
    s_gnt = 1'b1;
    s_rvalid = 1'b1;
    s_err = 1'b1;
    #1;
    tests_run++;
    if ({s_req, m_gnt, m_rvalid, m_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: s_req/m_gnt/m_rvalid/m_err=%b required 0", {s_req, m_gnt, m_rvalid, m_err});
    end
    tests_run++;
    if (outstanding !== '0 || resp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: outstanding=%0d resp_err=%b required 0 0", outstanding, resp_err);
    end
    tick();
    do_reset();
  endtask
  task automatic test_single();
    logic [DW-1:0] d0 = 32'hDEAD_0100;
    logic [DW-1:0] d1 = 32'hBEEF_0104;
    do_reset();
    set_m(0, 32'h100);
    s_gnt = 1'b1;
    #1;
    tests_run++;
    if (m_gnt !== 2'b01 || s_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL single_gnt0: m_gnt=%b s_addr=%h required 01 100", m_gnt, s_addr);
    end
    tick();
    set_m(0, 32'h104);
    #1;
    tests_run++;
    if (m_gnt !== 2'b01 || s_addr !== 32'h104 || outstanding !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_gnt1: m_gnt=%b s_addr=%h outstanding=%0d required 01 104 1", m_gnt, s_addr, outstanding);
    end
    tick();
    m_req = '0;
    s_rvalid = 1'b1;
    s_rdata = d0;
    #1;
    tests_run++;
    if (m_rvalid !== 2'b01 || m_rdata[0 +: DW] !== d0 || outstanding !== 3'd2) begin
      tests_failed++;
      $display("FAIL single_resp0: m_rvalid=%b rdata=%h outstanding=%0d required 01 %h 2", m_rvalid, m_rdata[0 +: DW], outstanding, d0);
    end
    tick();
    s_rdata = d1;
    #1;
    tests_run++;
    if (m_rvalid !== 2'b01 || m_rdata[0 +: DW] !== d1 || outstanding !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_resp1: m_rvalid=%b rdata=%h outstanding=%0d required 01 %h 1", m_rvalid, m_rdata[0 +: DW], outstanding, d1);
    end
    tick();
    s_rvalid = 1'b0;
    #1;
    tests_run++;
    if (m_rvalid !== 2'b00 || outstanding !== 3'd0) begin
      tests_failed++;
      $display("FAIL single_idle: m_rvalid=%b outstanding=%0d required 00 0", m_rvalid, outstanding);
    end
    tick();
  endtask
  task automatic test_round_robin();
    logic [N-1:0] e;
    do_reset();
    set_m(0, 32'h10);
    set_m(1, 32'h20);
    s_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      tests_run++;
      if (m_gnt !== e) begin
        tests_failed++;
        $display("FAIL rr_gnt%0d: m_gnt=%b required %b", k, m_gnt, e);
      end
      tick();
    end
    m_req = '0;
    s_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      tests_run++;
      if (m_rvalid !== e) begin
        tests_failed++;
        $display("FAIL rr_resp%0d: m_rvalid=%b required %b", k, m_rvalid, e);
      end
      tick();
    end
    s_rvalid = 1'b0;
  endtask
  task automatic test_lock();
    do_reset();
    set_m(0, 32'h10);
    s_gnt = 1'b1;
    tick();
    set_m(0, 32'hA0);
    s_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_m(1, 32'hB0);
      #1;
      tests_run++;
      if (s_addr !== 32'hA0 || m_gnt !== 2'b00 || s_req !== 1'b1) begin
        tests_failed++;
        $display("FAIL lock_hold%0d: s_addr=%h m_gnt=%b s_req=%b required a0 00 1", k, s_addr, m_gnt, s_req);
      end
      tick();
    end
    s_gnt = 1'b1;
    #1;
    tests_run++;
    if (s_addr !== 32'hA0 || m_gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL lock_release: s_addr=%h m_gnt=%b required a0 01", s_addr, m_gnt);
    end
    tick();
    m_req[0] = 1'b0;
    #1;
    tests_run++;
    if (s_addr !== 32'hB0 || m_gnt !== 2'b10) begin
      tests_failed++;
      $display("FAIL lock_next: s_addr=%h m_gnt=%b required b0 10", s_addr, m_gnt);
    end
    tick();
    m_req = '0;
  endtask
  task automatic test_full();
    do_reset();
    set_m(0, 32'h200);
    s_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++;
      if (m_gnt !== 2'b01) begin
        tests_failed++;
        $display("FAIL full_fill%0d: m_gnt=%b required 01", k, m_gnt);
      end
      tick();
    end
    #1;
    tests_run++;
    if (s_req !== 1'b0 || m_gnt !== 2'b00 || outstanding !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_block: s_req=%b m_gnt=%b outstanding=%0d required 0 00 4", s_req, m_gnt, outstanding);
    end
    tick();
    s_rvalid = 1'b1;
    #1;
    tests_run++;
    if (s_req !== 1'b0 || m_rvalid !== 2'b01) begin
      tests_failed++;
      $display("FAIL full_resp: s_req=%b m_rvalid=%b required 0 01", s_req, m_rvalid);
    end
    tick();
    s_rvalid = 1'b0;
    #1;
    tests_run++;
    if (s_req !== 1'b1 || m_gnt !== 2'b01 || outstanding !== 3'd3) begin
      tests_failed++;
      $display("FAIL full_regrant: s_req=%b m_gnt=%b outstanding=%0d required 1 01 3", s_req, m_gnt, outstanding);
    end
    tick();
    m_req = '0;
    s_gnt = 1'b0;
  endtask
  task automatic test_error();
    do_reset();
    set_m(1, 32'h300);
    s_gnt = 1'b1;
    #1;
    tests_run++;
    if (m_gnt !== 2'b10) begin
      tests_failed++;
      $display("FAIL err_gnt: m_gnt=%b required 10", m_gnt);
    end
    tick();
    m_req = '0;
    s_rvalid = 1'b1;
    s_err = 1'b1;
    #1;
    tests_run++;
    if (m_err !== 2'b10 || m_rvalid !== 2'b10) begin
      tests_failed++;
      $display("FAIL err_route: m_err=%b m_rvalid=%b required 10 10", m_err, m_rvalid);
    end
    tick();
    s_rvalid = 1'b0;
    #1;
    tests_run++;
    if (m_err !== 2'b00) begin
      tests_failed++;
      $display("FAIL err_pulse: m_err=%b required 00", m_err);
    end
    tick();
    s_err = 1'b0;
    s_rvalid = 1'b1;
    #1;
    tests_run++;
    if (m_rvalid !== 2'b00 || resp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_unexp: m_rvalid=%b resp_err=%b required 00 0", m_rvalid, resp_err);
    end
    tick();
    s_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (resp_err !== 1'b1) begin
        tests_failed++;
        $display("FAIL err_sticky%0d: resp_err=%b required 1", k, resp_err);
      end
      tick();
    end
    do_reset();
    #1;
    tests_run++;
    if (resp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: resp_err=%b required 0", resp_err);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    set_m(0, 32'h400);
    s_gnt = 1'b1;
    repeat (3) tick();
    #1;
    tests_run++;
    if (outstanding !== 3'd3) begin
      tests_failed++;
      $display("FAIL rmid_pre: outstanding=%0d required 3", outstanding);
    end
    rst = 1'b1;
    m_req = '1;
    s_rvalid = 1'b1;
    #1;
    tests_run++;
    if ({s_req, m_gnt, m_rvalid, m_err} !== '0 || outstanding !== '0) begin
      tests_failed++;
      $display("FAIL rmid_rst: outs=%b outstanding=%0d required 0 0", {s_req, m_gnt, m_rvalid, m_err}, outstanding);
    end
    tick();
    rst = 1'b0;
    m_req = '0;
    #1;
    tests_run++;
    if (m_rvalid !== 2'b00 || outstanding !== '0) begin
      tests_failed++;
      $display("FAIL rmid_late: m_rvalid=%b outstanding=%0d required 00 0", m_rvalid, outstanding);
    end
    tick();
    s_rvalid = 1'b0;
    set_m(0, 32'h500);
    set_m(1, 32'h600);
    #1;
    tests_run++;
    if (resp_err !== 1'b1 || m_gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL rmid_after: resp_err=%b m_gnt=%b required 1 01", resp_err, m_gnt);
    end
    tick();
    m_req = '0;
    s_gnt = 1'b0;
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_req[i] && $urandom_range(0, 2) == 0) begin
          m_req[i] = 1'b1;
          m_addr[i*AW +: AW] = $urandom;
          m_we[i] = $urandom_range(0, 1) == 1;
          m_be[i*BW +: BW] = BW'($urandom_range(0, 15));
          m_wdata[i*DW +: DW] = $urandom;
        end
      end
      s_gnt = $urandom_range(0, 3) != 0;
      s_rvalid = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      s_err = $urandom_range(0, 3) == 0;
      s_rdata = $urandom;
      #1;
      model_eval();
      tests_run++;
      if (s_req !== exp_sreq || m_gnt !== exp_gnt) begin
        tests_failed++;
        $display("FAIL rnd_req c%0d: s_req=%b m_gnt=%b required %b %b", c, s_req, m_gnt, exp_sreq, exp_gnt);
      end
      tests_run++;
      if (m_rvalid !== exp_rv || m_err !== exp_err) begin
        tests_failed++;
        $display("FAIL rnd_resp c%0d: m_rvalid=%b m_err=%b required %b %b", c, m_rvalid, m_err, exp_rv, exp_err);
      end
      tests_run++;
      if (outstanding !== CW'(exp_out) || resp_err !== exp_re) begin
        tests_failed++;
        $display("FAIL rnd_state c%0d: outstanding=%0d resp_err=%b required %0d %b", c, outstanding, resp_err, exp_out, exp_re);
      end
      tests_run++;
      if (m_rdata !== {N{s_rdata}}) begin
        tests_failed++;
        $display("FAIL rnd_rdata c%0d: m_rdata=%h required %h", c, m_rdata, {N{s_rdata}});
      end
      if (exp_sreq) begin
        tests_run++;
        if (s_addr !== m_addr[exp_sel*AW +: AW] || s_we !== m_we[exp_sel] ||
            s_be !== m_be[exp_sel*BW +: BW] || s_wdata !== m_wdata[exp_sel*DW +: DW]) begin
          tests_failed++;
          $display("FAIL rnd_mux c%0d: s_addr=%h s_we=%b s_be=%h s_wdata=%h required master %0d %h %b %h %h", c, s_addr, s_we, s_be, s_wdata,
                   exp_sel, m_addr[exp_sel*AW +: AW], m_we[exp_sel], m_be[exp_sel*BW +: BW], m_wdata[exp_sel*DW +: DW]);
        end
      end
      tick();
      for (int i = 0; i < N; i++) if (exp_gnt[i]) m_req[i] = 1'b0;
    end
    m_req = '0;
    s_gnt = 1'b0;
    s_rvalid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    m_req = '0;
    m_we = '0;
    m_be = '0;
    m_addr = '0;
    m_wdata = '0;
    s_gnt = 1'b0;
    s_rvalid = 1'b0;
    s_err = 1'b0;
    s_rdata = '0;
    mptr = 0;
    mlock = 1'b0;
    mlock_idx = 0;
    mresp_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_full();
    test_error();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
